sram_arbiter: RTL

//  Two-port arbiter and access sequencer for the external 1Mx8 async SRAM behind sram_1Mx8.

---
 rtl/sram_arbiter_pkg.sv | 32 +++
 rtl/sram_arbiter_rr_arb2.sv | 40 ++++
 rtl/sram_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the SRAM arbiter: state encodings, default bus
// widths, strobe idle level and the wait-counter load helper.
package sram_arbiter_pkg;

    localparam int ADDR_W_DEF = 20;
    localparam int DATA_W_DEF = 8;

    // Width of the ACCESS wait down-counter (0..15 extra cycles).
    localparam int CNT_W = 4;

    // Active-low SRAM strobes rest at this level.
    localparam logic STROBE_OFF = 1'b1;

    // Last-granted pointer value after reset; 1 means port 0 wins the first tie.
    localparam logic PTR_RESET = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    // Counter load value; out-of-range wait counts saturate at the counter maximum.
    function automatic logic [CNT_W-1:0] wait_load(input int wait_cycles);
        if (wait_cycles > (2**CNT_W) - 1) begin
            return '1;
        end
        return CNT_W'(wait_cycles);
    endfunction

endpackage

// File: rtl/sram_arbiter_rr_arb2.sv
// Two-way request picker for the SRAM arbiter.
// Default: round-robin, a tie goes to the port that was not granted last.
// With SRAM_ARB_FIXED_PRI_EN defined, port 0 always wins a tie.
// A lone request is granted regardless of the pointer.
module sram_arbiter_rr_arb2
    import sram_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // Index of the most recently granted port.
    logic       last_reg;
    // prefer[gi] set means port gi wins when both ports request.
    logic [1:0] prefer;

`ifdef SRAM_ARB_FIXED_PRI_EN
    assign prefer = 2'b01;
`else
    assign prefer = {~last_reg, last_reg};
`endif

    // Per-port grant: own request and either no competitor or tie preference.
    for (genvar gi = 0; gi < 2; gi++) begin : g_grant
        assign grant[gi] = req[gi] & (~req[1-gi] | prefer[gi]);
    end

    // Pointer moves only when a grant is actually taken by the sequencer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_reg <= PTR_RESET;
        end else if (advance) begin
            last_reg <= grant[1];
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter and access sequencer for an external async SRAM.
// One access at a time: IDLE -> SETUP -> ACCESS (WAIT_CYCLES+1) -> HOLD -> IDLE.
// All SRAM strobes, the address, write data and acks are registered.
// Build option: define SRAM_ARB_FIXED_PRI_EN for fixed port-0 priority on ties.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic              i_we0,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_ack0,
    output logic              o_ack1,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_sram_dq_out,
    output logic              o_sram_dq_oe,
    input  logic [DATA_W-1:0] i_sram_dq_in,
    output logic              o_sram_ce_n,
    output logic              o_sram_oe_n,
    output logic              o_sram_we_n
);

    localparam logic [CNT_W-1:0] WAIT_LD = wait_load(WAIT_CYCLES);

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              gnt_port_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              ce_n_reg;
    logic              oe_n_reg;
    logic              we_n_reg;
    logic              dq_oe_reg;
    logic              busy_reg;
    logic [1:0]        ack_reg;

    logic [1:0]        req_vec;
    logic [1:0]        grant;
    logic              advance;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign req_vec = {i_req1, i_req0};
    // A grant is only consumed from IDLE; requests during an access wait.
    assign advance = (state_reg == ST_IDLE) && (req_vec != 2'b00);

    sram_arbiter_rr_arb2 u_arb (
        .clk     (i_clk),
        .reset_n (i_reset_n),
        .req     (req_vec),
        .advance (advance),
        .grant   (grant)
    );

    // Steer the winning port's command onto the latch inputs.
    always_comb begin
        sel_we    = i_we0;
        sel_addr  = i_addr0;
        sel_wdata = i_wdata0;
        if (grant[1]) begin
            sel_we    = i_we1;
            sel_addr  = i_addr1;
            sel_wdata = i_wdata1;
        end
    end

    // Access sequencer: state, wait counter, latched command and registered pin levels.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            gnt_port_reg <= 1'b0;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            rdata_reg    <= '0;
            ce_n_reg     <= STROBE_OFF;
            oe_n_reg     <= STROBE_OFF;
            we_n_reg     <= STROBE_OFF;
            dq_oe_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            ack_reg      <= 2'b00;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (advance) begin
                        state_reg    <= ST_SETUP;
                        gnt_port_reg <= grant[1];
                        we_reg       <= sel_we;
                        addr_reg     <= sel_addr;
                        wdata_reg    <= sel_wdata;
                        ce_n_reg     <= 1'b0;
                        // Reads enable the output buffer right away; writes
                        // drive the bus instead, so the two never overlap.
                        oe_n_reg     <= sel_we;
                        dq_oe_reg    <= sel_we;
                        we_n_reg     <= STROBE_OFF;
                        busy_reg     <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    state_reg <= ST_ACCESS;
                    cnt_reg   <= WAIT_LD;
                    we_n_reg  <= ~we_reg;
                end
                ST_ACCESS: begin
                    if (cnt_reg == '0) begin
                        state_reg <= ST_HOLD;
                        we_n_reg  <= STROBE_OFF;
                        oe_n_reg  <= STROBE_OFF;
                        if (!we_reg) begin
                            rdata_reg <= i_sram_dq_in;
                        end
                        ack_reg <= gnt_port_reg ? 2'b10 : 2'b01;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                ST_HOLD: begin
                    // dq_oe stayed on through HOLD so write data outlives the WE rise.
                    state_reg <= ST_IDLE;
                    ce_n_reg  <= STROBE_OFF;
                    dq_oe_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                    ack_reg   <= 2'b00;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_ack0        = ack_reg[0];
    assign o_ack1        = ack_reg[1];
    assign o_rdata       = rdata_reg;
    assign o_busy        = busy_reg;
    assign o_sram_addr   = addr_reg;
    assign o_sram_dq_out = wdata_reg;
    assign o_sram_dq_oe  = dq_oe_reg;
    assign o_sram_ce_n   = ce_n_reg;
    assign o_sram_oe_n   = oe_n_reg;
    assign o_sram_we_n   = we_n_reg;

endmodule
